truth_table_sequencer: RTL and testbench

TRUTH_TABLE_SEQUENCER -- requirements
Module: truth_table_sequencer

---
 rtl/truth_table_pkg.sv | 50 +++++
 rtl/settle_timer.sv | 41 ++++
 rtl/truth_table_sequencer.sv | 111 +++++++++++
 tb/tb_truth_table_sequencer.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/truth_table_pkg.sv
// Shared types and constants for the two-input gate truth-table sequencer.
// Rows are packed {xnor,xor,nor,nand,not,or,and}, bit 0 = and.
package truth_table_pkg;

  localparam int unsigned GATE_W = 7;
  localparam int unsigned VEC_W  = 2;
  localparam int unsigned CNT_W  = 4;

  localparam int unsigned GATE_AND  = 0;
  localparam int unsigned GATE_OR   = 1;
  localparam int unsigned GATE_NOT  = 2;
  localparam int unsigned GATE_NAND = 3;
  localparam int unsigned GATE_NOR  = 4;
  localparam int unsigned GATE_XOR  = 5;
  localparam int unsigned GATE_XNOR = 6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CHECK,
    ST_DONE
  } state_e;

  // Golden row for stimulus {a,b}; NOT observes input a only.
  function automatic logic [GATE_W-1:0] gate_row(input logic a, input logic b);
    logic [GATE_W-1:0] r;
    r            = '0;
    r[GATE_AND]  = a & b;
    r[GATE_OR]   = a | b;
    r[GATE_NOT]  = ~a;
    r[GATE_NAND] = ~(a & b);
    r[GATE_NOR]  = ~(a | b);
    r[GATE_XOR]  = a ^ b;
    r[GATE_XNOR] = ~(a ^ b);
    return r;
  endfunction

  // Indexed by {a,b}: 00->1011100, 01->0101110, 10->0101010, 11->1000011.
  localparam logic [3:0][GATE_W-1:0] EXP_ROWS = {
    gate_row(1'b1, 1'b1),
    gate_row(1'b1, 1'b0),
    gate_row(1'b0, 1'b1),
    gate_row(1'b0, 1'b0)
  };

  function automatic logic [GATE_W-1:0] expected_row(input logic [VEC_W-1:0] vec);
    return EXP_ROWS[vec];
  endfunction

endpackage

// File: rtl/settle_timer.sv
// Hold-time counter: load starts a LEN-cycle window, expire_o is high in its last cycle.
module settle_timer
  import truth_table_pkg::*;
#(
  parameter int unsigned LEN = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  output logic expire_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             expire_q, expire_d;

  // cnt_q holds the cycles remaining after the current one
  always_comb begin
    cnt_d    = cnt_q;
    expire_d = 1'b0;
    if (load_i) begin
      cnt_d    = CNT_W'(LEN - 1);
      expire_d = (LEN == 1);
    end else if (cnt_q != '0) begin
      cnt_d    = cnt_q - CNT_W'(1);
      expire_d = (cnt_q == CNT_W'(1));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      expire_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      expire_q <= expire_d;
    end
  end

  assign expire_o = expire_q;

endmodule

// File: rtl/truth_table_sequencer.sv
// Walks {a,b} through 00..11, holds each vector SETTLE_CYCLES cycles, then checks
// the gate-under-test outputs against the golden truth table and reports a verdict.
module truth_table_sequencer
  import truth_table_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [GATE_W-1:0] gate_in,
  output logic              a,
  output logic              b,
  output logic              busy,
  output logic              result_valid,
  output logic [VEC_W-1:0]  result_idx,
  output logic [GATE_W-1:0] result_row,
  output logic              done,
  output logic              pass,
  output logic [GATE_W-1:0] err_mask
);

  state_e            state_q;
  logic [VEC_W-1:0]  vec_q;
  logic              busy_q;
  logic              result_valid_q;
  logic [VEC_W-1:0]  result_idx_q;
  logic [GATE_W-1:0] result_row_q;
  logic              done_q;
  logic              pass_q;
  logic [GATE_W-1:0] err_mask_q;

  logic              timer_load_c;
  logic              timer_expire;
  logic [GATE_W-1:0] mismatch_c;

  assign mismatch_c   = gate_in ^ expected_row(vec_q);
  assign timer_load_c = ((state_q == ST_IDLE) && start) ||
                        ((state_q == ST_CHECK) && (vec_q != VEC_W'(3)));

  settle_timer #(
    .LEN(SETTLE_CYCLES)
  ) u_settle_timer (
    .clk     (clk),
    .rst     (rst),
    .load_i  (timer_load_c),
    .expire_o(timer_expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      vec_q          <= '0;
      busy_q         <= 1'b0;
      result_valid_q <= 1'b0;
      result_idx_q   <= '0;
      result_row_q   <= '0;
      done_q         <= 1'b0;
      pass_q         <= 1'b0;
      err_mask_q     <= '0;
    end else begin
      result_valid_q <= 1'b0;
      done_q         <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q    <= ST_SETTLE;
            vec_q      <= '0;
            busy_q     <= 1'b1;
            pass_q     <= 1'b0;
            err_mask_q <= '0;
          end
        end
        ST_SETTLE: begin
          if (timer_expire) state_q <= ST_CHECK;
        end
        ST_CHECK: begin
          err_mask_q     <= err_mask_q | mismatch_c;
          result_valid_q <= 1'b1;
          result_idx_q   <= vec_q;
          result_row_q   <= gate_in;
          // Verdict is registered together with done so both appear in the DONE cycle
          if (vec_q == VEC_W'(3)) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
            pass_q  <= ((err_mask_q | mismatch_c) == '0);
          end else begin
            state_q <= ST_SETTLE;
            vec_q   <= vec_q + VEC_W'(1);
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign a            = vec_q[1];
  assign b            = vec_q[0];
  assign busy         = busy_q;
  assign result_valid = result_valid_q;
  assign result_idx   = result_idx_q;
  assign result_row   = result_row_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign err_mask     = err_mask_q;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Scoreboard bench: two sequencers (SETTLE_CYCLES 2 and 1) driving a modelled gate
// under test with injectable faults; expected events are queued when a run starts.
module tb_truth_table_sequencer;

  localparam int unsigned S0 = 2;
  localparam int unsigned S1 = 1;

  logic       clk = 1'b0;
  logic       rst0, rst1, start0, start1;
  logic [6:0] gate0, gate1;
  logic       a0, b0, busy0, rv0, done0, pass0;
  logic       a1, b1, busy1, rv1, done1, pass1;
  logic [1:0] idx0, idx1;
  logic [6:0] row0, row1, err0, err1;
  logic [6:0] flt0 [4];
  logic [6:0] flt1 [4];

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int cyc;
    bit is_done;
    int idx;
    int row;
    int ab;
    int pass;
    int err;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference gates from the count of ones on the two inputs
  function automatic logic [6:0] truth(input logic x, input logic y);
    int s;
    logic [6:0] r;
    s    = int'(x) + int'(y);
    r[0] = (s == 2);
    r[1] = (s >= 1);
    r[2] = (x == 1'b0);
    r[3] = (s < 2);
    r[4] = (s == 0);
    r[5] = (s == 1);
    r[6] = (s != 1);
    return r;
  endfunction

  always_comb gate0 = truth(a0, b0) ^ flt0[{a0, b0}];
  always_comb gate1 = truth(a1, b1) ^ flt1[{a1, b1}];

  truth_table_sequencer #(.SETTLE_CYCLES(S0)) u_dut0 (
    .clk(clk), .rst(rst0), .start(start0), .gate_in(gate0), .a(a0), .b(b0),
    .busy(busy0), .result_valid(rv0), .result_idx(idx0), .result_row(row0),
    .done(done0), .pass(pass0), .err_mask(err0)
  );

  truth_table_sequencer #(.SETTLE_CYCLES(S1)) u_dut1 (
    .clk(clk), .rst(rst1), .start(start1), .gate_in(gate1), .a(a1), .b(b1),
    .busy(busy1), .result_valid(rv1), .result_idx(idx1), .result_row(row1),
    .done(done1), .pass(pass1), .err_mask(err1)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Queue the four results and the done verdict of a run whose start is sampled in cycle e0
  task automatic plan_run(input int d, input int e0, input logic [3:0][6:0] f);
    int         s;
    logic [6:0] acc;
    exp_t       e;
    s   = (d == 0) ? int'(S0) : int'(S1);
    acc = '0;
    for (int i = 0; i < 4; i++) begin
      acc       = acc | f[i];
      e.cyc     = e0 + (i + 1) * (s + 1) + 1;
      e.is_done = 1'b0;
      e.idx     = i;
      e.row     = int'(truth(i[1], i[0]) ^ f[i]);
      e.ab      = (i < 3) ? i + 1 : 3;
      e.pass    = 0;
      e.err     = 0;
      if (d == 0) q0.push_back(e); else q1.push_back(e);
    end
    e.cyc     = e0 + 4 * (s + 1) + 1;
    e.is_done = 1'b1;
    e.idx     = 0;
    e.row     = 0;
    e.ab      = 3;
    e.pass    = (acc == '0) ? 1 : 0;
    e.err     = int'(acc);
    if (d == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  function automatic bit take(input int d, output exp_t e);
    e = '{0, 1'b0, 0, 0, 0, 0, 0};
    if (d == 0) begin
      if (q0.size() == 0) return 1'b0;
      e = q0.pop_front();
    end else begin
      if (q1.size() == 0) return 1'b0;
      e = q1.pop_front();
    end
    return 1'b1;
  endfunction

  task automatic mon(input int d, input logic rv, input logic dn, input logic [1:0] idx,
                     input logic [6:0] row, input logic ps, input logic [6:0] em,
                     input logic [1:0] ab, input logic bz);
    exp_t  e;
    string tag;
    bit    late;
    tag = (d == 0) ? "dut0" : "dut1";
    if (rv) begin
      if (!take(d, e)) chk({tag, "_unexpected_result_valid"}, int'(rv), 0);
      else begin
        chk({tag, "_result_kind"}, int'(e.is_done), 0);
        chk({tag, "_result_cycle"}, cyc, e.cyc);
        chk({tag, "_result_idx"}, int'(idx), e.idx);
        chk({tag, "_result_row"}, int'(row), e.row);
        chk({tag, "_result_ab"}, int'(ab), e.ab);
        chk({tag, "_result_busy"}, int'(bz), 1);
      end
    end
    if (dn) begin
      if (!take(d, e)) chk({tag, "_unexpected_done"}, int'(dn), 0);
      else begin
        chk({tag, "_done_kind"}, int'(e.is_done), 1);
        chk({tag, "_done_cycle"}, cyc, e.cyc);
        chk({tag, "_done_pass"}, int'(ps), e.pass);
        chk({tag, "_done_err_mask"}, int'(em), e.err);
        chk({tag, "_done_ab"}, int'(ab), e.ab);
        chk({tag, "_done_busy"}, int'(bz), 1);
      end
    end
    late = (d == 0) ? (q0.size() != 0 && q0[0].cyc < cyc) : (q1.size() != 0 && q1[0].cyc < cyc);
    if (late && take(d, e)) chk({tag, "_missed_event_cycle"}, cyc, e.cyc);
  endtask

  always @(negedge clk) begin
    mon(0, rv0, done0, idx0, row0, pass0, err0, {a0, b0}, busy0);
    mon(1, rv1, done1, idx1, row1, pass1, err1, {a1, b1}, busy1);
  end

  task automatic zero_check(input string tag, input logic aa, input logic bb, input logic bz,
                            input logic rv, input logic [1:0] ix, input logic [6:0] rw,
                            input logic dn, input logic ps, input logic [6:0] em);
    chk({tag, "_a"}, int'(aa), 0);
    chk({tag, "_b"}, int'(bb), 0);
    chk({tag, "_busy"}, int'(bz), 0);
    chk({tag, "_result_valid"}, int'(rv), 0);
    chk({tag, "_result_idx"}, int'(ix), 0);
    chk({tag, "_result_row"}, int'(rw), 0);
    chk({tag, "_done"}, int'(dn), 0);
    chk({tag, "_pass"}, int'(ps), 0);
    chk({tag, "_err_mask"}, int'(em), 0);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic set_flt(input int d, input logic [3:0][6:0] f);
    for (int i = 0; i < 4; i++) begin
      if (d == 0) flt0[i] = f[i]; else flt1[i] = f[i];
    end
  endtask

  task automatic start_run0(input logic [3:0][6:0] f, output int e0);
    @(negedge clk);
    set_flt(0, f);
    e0     = cyc;
    start0 = 1'b1;
    plan_run(0, e0, f);
    @(negedge clk);
    start0 = 1'b0;
  endtask

  // Verdict, err_mask and the last vector must persist in IDLE after the run
  task automatic idle_check0(input int e0, input logic [3:0][6:0] f);
    logic [6:0] acc;
    acc = f[0] | f[1] | f[2] | f[3];
    wait_cyc(e0 + 4 * (int'(S0) + 1) + 3);
    chk("dut0_idle_busy", int'(busy0), 0);
    chk("dut0_idle_ab", int'({a0, b0}), 3);
    chk("dut0_idle_done", int'(done0), 0);
    chk("dut0_idle_pass", int'(pass0), (acc == '0) ? 1 : 0);
    chk("dut0_idle_err_mask", int'(err0), int'(acc));
  endtask

  function automatic logic [3:0][6:0] rand_faults();
    logic [3:0][6:0] f;
    for (int i = 0; i < 4; i++) f[i] = ($urandom_range(0, 2) == 0) ? 7'($urandom) : 7'd0;
    return f;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0][6:0] f;
    logic [6:0]      acc;
    int              e0;
    rst0 = 1'b1; rst1 = 1'b1; start0 = 1'b0; start1 = 1'b0;
    f = '0;
    set_flt(0, f);
    set_flt(1, f);
    #1;
    zero_check("reset0", a0, b0, busy0, rv0, idx0, row0, done0, pass0, err0);
    zero_check("reset1", a1, b1, busy1, rv1, idx1, row1, done1, pass1, err1);
    repeat (2) @(negedge clk);
    rst0 = 1'b0; rst1 = 1'b0;
    repeat (2) @(negedge clk);

    // Correct gate, then nand stuck-high at vector 11, then a clean run again
    f = '0;
    start_run0(f, e0);
    chk("dut0_busy_after_start", int'(busy0), 1);
    chk("dut0_ab_after_start", int'({a0, b0}), 0);
    idle_check0(e0, f);
    f = '0; f[3] = 7'b0001000;
    start_run0(f, e0);
    idle_check0(e0, f);
    f = '0;
    start_run0(f, e0);
    chk("dut0_err_cleared_at_start", int'(err0), 0);
    idle_check0(e0, f);

    // Second start pulse while busy must be ignored
    f = '0;
    start_run0(f, e0);
    wait_cyc(e0 + 5);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    idle_check0(e0, f);

    // Asynchronous reset mid-run: outputs clear at once and the run is abandoned
    f = '0; f[0] = 7'b0000001;
    start_run0(f, e0);
    wait_cyc(e0 + 7);
    #2;
    rst0 = 1'b1;
    q0.delete();
    #1;
    zero_check("midrun_reset", a0, b0, busy0, rv0, idx0, row0, done0, pass0, err0);
    @(negedge clk);
    #2;
    rst0 = 1'b0;
    repeat (6) @(negedge clk);
    chk("post_reset_busy", int'(busy0), 0);
    f = '0;
    start_run0(f, e0);
    idle_check0(e0, f);

    for (int r = 0; r < 12; r++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      f = rand_faults();
      start_run0(f, e0);
      idle_check0(e0, f);
    end

    // Start held high on the 1-cycle-settle instance: back-to-back runs
    @(negedge clk);
    f = '0; f[$urandom_range(0, 3)] = 7'($urandom_range(1, 127));
    set_flt(1, f);
    e0     = cyc;
    start1 = 1'b1;
    plan_run(1, e0, f);
    for (int r = 1; r < 6; r++) begin
      wait_cyc(e0 + 9);
      f = '0;
      if (r % 2 == 0) f[$urandom_range(0, 3)] = 7'($urandom_range(1, 127));
      set_flt(1, f);
      e0 = e0 + 10;
      plan_run(1, e0, f);
      wait_cyc(e0 + 1);
      chk("dut1_restart_busy", int'(busy1), 1);
      chk("dut1_restart_err_cleared", int'(err1), 0);
      chk("dut1_restart_pass_cleared", int'(pass1), 0);
    end
    wait_cyc(e0 + 9);
    start1 = 1'b0;
    wait_cyc(e0 + 12);
    acc = f[0] | f[1] | f[2] | f[3];
    chk("dut1_idle_busy", int'(busy1), 0);
    chk("dut1_idle_ab", int'({a1, b1}), 3);
    chk("dut1_idle_pass", int'(pass1), (acc == '0) ? 1 : 0);
    chk("dut1_idle_err_mask", int'(err1), int'(acc));

    repeat (4) @(negedge clk);
    chk("dut0_queue_drained", q0.size(), 0);
    chk("dut1_queue_drained", q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
